// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/load requesters, the register file and the hazard unit.
// Forwarding signals exist only when REGFILE_WB_BYPASS_EN is defined.
interface regfile_wb_arbiter_if;
   logic        ALU_wb_valid;
   logic [4:0]  ALU_wb_address;
   logic [31:0] ALU_wb_value;
   logic        ALU_wb_ready;
   logic        MEM_wb_valid;
   logic [4:0]  MEM_wb_address;
   logic [31:0] MEM_wb_value;
   logic        MEM_wb_ready;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        REG_write_enable;
   logic [4:0]  REG_write_address;
   logic [31:0] REG_write_value;
   logic        WB_hazard_rs1;
   logic        WB_hazard_rs2;
   // Round-robin pointer: 0 = ALU granted last, 1 = MEM granted last
   logic        dbg_last_grant;
`ifdef REGFILE_WB_BYPASS_EN
   logic        WB_fwd_rs1_valid;
   logic [31:0] WB_fwd_rs1_data;
   logic        WB_fwd_rs2_valid;
   logic [31:0] WB_fwd_rs2_data;
`endif

   // Handshake: a requester raises valid with address/value and holds all
   // three stable until ready; the transfer happens on valid & ready at the edge.
   modport slave (
      input  ALU_wb_valid, ALU_wb_address, ALU_wb_value,
      input  MEM_wb_valid, MEM_wb_address, MEM_wb_value,
      input  rs1, rs2,
      output ALU_wb_ready, MEM_wb_ready,
      output REG_write_enable, REG_write_address, REG_write_value,
      output WB_hazard_rs1, WB_hazard_rs2,
`ifdef REGFILE_WB_BYPASS_EN
      output WB_fwd_rs1_valid, WB_fwd_rs1_data, WB_fwd_rs2_valid, WB_fwd_rs2_data,
`endif
      output dbg_last_grant
   );

   modport master (
      output ALU_wb_valid, ALU_wb_address, ALU_wb_value,
      output MEM_wb_valid, MEM_wb_address, MEM_wb_value,
      output rs1, rs2,
      input  ALU_wb_ready, MEM_wb_ready,
      input  REG_write_enable, REG_write_address, REG_write_value,
      input  WB_hazard_rs1, WB_hazard_rs2,
`ifdef REGFILE_WB_BYPASS_EN
      input  WB_fwd_rs1_valid, WB_fwd_rs1_data, WB_fwd_rs2_valid, WB_fwd_rs2_data,
`endif
      input  dbg_last_grant
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin ALU/load writeback arbiter with one-cycle output stage and hazard detect.
// Optional feature macro: REGFILE_WB_BYPASS_EN (forwarding from the output stage).
module regfile_wb_arbiter (
   input  logic SYS_clk,
   input  logic SYS_reset,
   regfile_wb_arbiter_if.slave wb
);

   typedef enum logic {
      LAST_ALU = 1'b0,
      LAST_MEM = 1'b1
   } last_grant_e;

   last_grant_e last_q, last_d;
   logic        wr_en_q, wr_en_d;
   logic [4:0]  wr_addr_q, wr_addr_d;
   logic [31:0] wr_val_q, wr_val_d;
   logic        grant_alu, grant_mem;
   logic        stage_match_en;

   function automatic logic reg_hazard(
      input logic [4:0] rs,
      input logic       a_v,
      input logic [4:0] a_addr,
      input logic       m_v,
      input logic [4:0] m_addr,
      input logic       o_v,
      input logic [4:0] o_addr
   );
      return (rs != 5'd0) &&
             ((a_v && (a_addr == rs)) || (m_v && (m_addr == rs)) || (o_v && (o_addr == rs)));
   endfunction

   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) begin
         last_q    <= LAST_MEM;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 5'd0;
         wr_val_q  <= 32'd0;
      end else begin
         last_q    <= last_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_val_q  <= wr_val_d;
      end
   end

   always_comb begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      last_d    = last_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_val_d  = wr_val_q;
      // On a tie the requester that did not win last time goes first
      if (!SYS_reset) begin
         if (wb.ALU_wb_valid && (!wb.MEM_wb_valid || (last_q == LAST_MEM))) begin
            grant_alu = 1'b1;
         end else if (wb.MEM_wb_valid) begin
            grant_mem = 1'b1;
         end
      end
      if (grant_alu) begin
         last_d    = LAST_ALU;
         wr_en_d   = (wb.ALU_wb_address != 5'd0);
         wr_addr_d = wb.ALU_wb_address;
         wr_val_d  = wb.ALU_wb_value;
      end else if (grant_mem) begin
         last_d    = LAST_MEM;
         wr_en_d   = (wb.MEM_wb_address != 5'd0);
         wr_addr_d = wb.MEM_wb_address;
         wr_val_d  = wb.MEM_wb_value;
      end
   end

   assign wb.ALU_wb_ready      = grant_alu;
   assign wb.MEM_wb_ready      = grant_mem;
   assign wb.REG_write_enable  = wr_en_q;
   assign wb.REG_write_address = wr_addr_q;
   assign wb.REG_write_value   = wr_val_q;
   assign wb.dbg_last_grant    = last_q;

`ifdef REGFILE_WB_BYPASS_EN
   // The landing write is forwarded instead, so it no longer counts as a hazard
   assign stage_match_en      = 1'b0;
   assign wb.WB_fwd_rs1_valid = (wb.rs1 != 5'd0) && wr_en_q && (wb.rs1 == wr_addr_q);
   assign wb.WB_fwd_rs1_data  = wr_val_q;
   assign wb.WB_fwd_rs2_valid = (wb.rs2 != 5'd0) && wr_en_q && (wb.rs2 == wr_addr_q);
   assign wb.WB_fwd_rs2_data  = wr_val_q;
`else
   assign stage_match_en = wr_en_q;
`endif

   assign wb.WB_hazard_rs1 = reg_hazard(wb.rs1, wb.ALU_wb_valid, wb.ALU_wb_address,
                                        wb.MEM_wb_valid, wb.MEM_wb_address,
                                        stage_match_en, wr_addr_q);
   assign wb.WB_hazard_rs2 = reg_hazard(wb.rs2, wb.ALU_wb_valid, wb.ALU_wb_address,
                                        wb.MEM_wb_valid, wb.MEM_wb_address,
                                        stage_match_en, wr_addr_q);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; covers both builds of REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_arbiter;

   logic SYS_clk;
   logic SYS_reset;
   int   total;
   int   bad;
   logic [36:0] exp_q[$];

   regfile_wb_arbiter_if wb ();

   regfile_wb_arbiter dut (
      .SYS_clk   (SYS_clk),
      .SYS_reset (SYS_reset),
      .wb        (wb.slave)
   );

   // clock / reset
   initial SYS_clk = 1'b0;
   always #5 SYS_clk = ~SYS_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic drive_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
      wb.ALU_wb_valid   = v;
      wb.ALU_wb_address = a;
      wb.ALU_wb_value   = d;
   endtask

   task automatic drive_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
      wb.MEM_wb_valid   = v;
      wb.MEM_wb_address = a;
      wb.MEM_wb_value   = d;
   endtask

   task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   // scoreboard: the output stage must match the oldest expected write, or be idle
   task automatic check_out(input string tag);
      logic [36:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_we"}, {31'd0, wb.REG_write_enable}, 32'd1);
         chk({tag, "_addr"}, {27'd0, wb.REG_write_address}, {27'd0, e[36:32]});
         chk({tag, "_val"}, wb.REG_write_value, e[31:0]);
      end else begin
         chk({tag, "_we"}, {31'd0, wb.REG_write_enable}, 32'd0);
      end
   endtask

   task automatic chk_ready(input string tag, input logic a, input logic m);
      chk({tag, "_alu_rdy"}, {31'd0, wb.ALU_wb_ready}, {31'd0, a});
      chk({tag, "_mem_rdy"}, {31'd0, wb.MEM_wb_ready}, {31'd0, m});
   endtask

   task automatic edge_sample();
      @(posedge SYS_clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      SYS_reset = 1'b1;
      drive_alu(1'b0, 5'd0, 32'd0);
      drive_mem(1'b0, 5'd0, 32'd0);
      wb.rs1 = 5'd0;
      wb.rs2 = 5'd0;

      // reset: requests pending but never granted
      @(negedge SYS_clk);
      drive_alu(1'b1, 5'd6, 32'h0000_0066);
      drive_mem(1'b1, 5'd8, 32'h0000_0088);
      #1;
      chk_ready("rst", 1'b0, 1'b0);
      edge_sample();
      check_out("rst");
      chk("rst_addr", {27'd0, wb.REG_write_address}, 32'd0);
      chk("rst_val", wb.REG_write_value, 32'd0);

      // single ALU write, latency one, then idle
      @(negedge SYS_clk);
      SYS_reset = 1'b0;
      drive_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
      drive_mem(1'b0, 5'd0, 32'd0);
      #1;
      chk_ready("alu1", 1'b1, 1'b0);
      expect_write(5'd5, 32'hDEAD_BEEF);
      edge_sample();
      check_out("alu1_wr");
      @(negedge SYS_clk);
      drive_alu(1'b0, 5'd0, 32'd0);
      edge_sample();
      check_out("alu1_idle");

      // re-reset, then continuous ties alternate starting with ALU
      @(negedge SYS_clk);
      SYS_reset = 1'b1;
      edge_sample();
      @(negedge SYS_clk);
      SYS_reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge SYS_clk);
         drive_alu(1'b1, 5'd3, 32'h1111_1111);
         drive_mem(1'b1, 5'd4, 32'h2222_2222);
         #1;
         if ((i % 2) == 0) begin
            chk_ready($sformatf("rr%0d", i), 1'b1, 1'b0);
            expect_write(5'd3, 32'h1111_1111);
         end else begin
            chk_ready($sformatf("rr%0d", i), 1'b0, 1'b1);
            expect_write(5'd4, 32'h2222_2222);
         end
         edge_sample();
         check_out($sformatf("rr%0d_wr", i));
      end

      // load to x0: granted, consumed, no write strobe
      @(negedge SYS_clk);
      drive_alu(1'b0, 5'd0, 32'd0);
      drive_mem(1'b1, 5'd0, 32'hFFFF_FFFF);
      wb.rs1 = 5'd0;
      #1;
      chk_ready("x0", 1'b0, 1'b1);
      chk("x0_haz1", {31'd0, wb.WB_hazard_rs1}, 32'd0);
      edge_sample();
      check_out("x0_wr");

      // ALU-only grant so MEM wins the following tie
      @(negedge SYS_clk);
      drive_mem(1'b0, 5'd0, 32'd0);
      drive_alu(1'b1, 5'd1, 32'h0000_0001);
      #1;
      chk_ready("pre_haz", 1'b1, 1'b0);
      expect_write(5'd1, 32'h0000_0001);
      edge_sample();
      check_out("pre_haz_wr");

      // ALU addr 7 held back; hazard visible on rs1 only
      @(negedge SYS_clk);
      drive_alu(1'b1, 5'd7, 32'hA5A5_A5A5);
      drive_mem(1'b1, 5'd10, 32'h0BAD_F00D);
      wb.rs1 = 5'd7;
      wb.rs2 = 5'd0;
      #1;
      chk_ready("haz_tie", 1'b0, 1'b1);
      chk("haz_tie_h1", {31'd0, wb.WB_hazard_rs1}, 32'd1);
      chk("haz_tie_h2", {31'd0, wb.WB_hazard_rs2}, 32'd0);
      expect_write(5'd10, 32'h0BAD_F00D);
      edge_sample();
      check_out("haz_mem_wr");
      @(negedge SYS_clk);
      drive_mem(1'b0, 5'd0, 32'd0);
      #1;
      chk_ready("haz_alu", 1'b1, 1'b0);
      chk("haz_alu_h1", {31'd0, wb.WB_hazard_rs1}, 32'd1);
      expect_write(5'd7, 32'hA5A5_A5A5);
      edge_sample();
      check_out("haz_alu_wr");
      @(negedge SYS_clk);
      drive_alu(1'b0, 5'd0, 32'd0);
      #1;
`ifdef REGFILE_WB_BYPASS_EN
      chk("fwd_h1", {31'd0, wb.WB_hazard_rs1}, 32'd0);
      chk("fwd_v1", {31'd0, wb.WB_fwd_rs1_valid}, 32'd1);
      chk("fwd_d1", wb.WB_fwd_rs1_data, 32'hA5A5_A5A5);
      chk("fwd_v2", {31'd0, wb.WB_fwd_rs2_valid}, 32'd0);
`else
      chk("stage_h1", {31'd0, wb.WB_hazard_rs1}, 32'd1);
`endif
      chk("stage_h2", {31'd0, wb.WB_hazard_rs2}, 32'd0);
      edge_sample();
      check_out("haz_idle");
      chk("landed_h1", {31'd0, wb.WB_hazard_rs1}, 32'd0);

      // mid-operation reset drops the staged write and restores ALU tie priority
      @(negedge SYS_clk);
      wb.rs1 = 5'd0;
      drive_alu(1'b1, 5'd9, 32'h1234_5678);
      #1;
      chk_ready("mid", 1'b1, 1'b0);
      expect_write(5'd9, 32'h1234_5678);
      edge_sample();
      check_out("mid_wr");
      @(negedge SYS_clk);
      drive_alu(1'b0, 5'd0, 32'd0);
      SYS_reset = 1'b1;
      edge_sample();
      check_out("mid_rst");
      @(negedge SYS_clk);
      SYS_reset = 1'b0;
      drive_alu(1'b1, 5'd11, 32'h0000_00AA);
      drive_mem(1'b1, 5'd12, 32'h0000_00BB);
      #1;
      chk_ready("post_rst_tie", 1'b1, 1'b0);
      expect_write(5'd11, 32'h0000_00AA);
      edge_sample();
      check_out("post_rst_wr");

      chk("sb_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have these ports:
- SYS_clk  in  1  sole clock; all state updates on the rising edge.
- SYS_reset  in  1  synchronous, active-high reset.
- ALU_wb_valid  in  1  ALU writeback request.
- ALU_wb_address  in  5  ALU destination register.
- ALU_wb_value  in  32  ALU result.
- ALU_wb_ready  out  1  ALU request granted this cycle.
- MEM_wb_valid  in  1  load writeback request.
- MEM_wb_address  in  5  load destination register.
- MEM_wb_value  in  32  load data.
- MEM_wb_ready  out  1  load request granted this cycle.
- rs1  in  5  hazard-query register address, port 1.
- rs2  in  5  hazard-query register address, port 2.
- REG_write_enable  out  1  register-file write strobe.
- REG_write_address  out  5  register-file write address.
- REG_write_value  out  32  register-file write data.
- WB_hazard_rs1  out  1  rs1 has a pending, unlanded write.
- WB_hazard_rs2  out  1  rs2 has a pending, unlanded write.

Function
REQ-002 SHALL grant at most one requester per cycle; ready = grant, combinational from the valids and the priority pointer.
REQ-003 SHALL, with one valid requester, grant it.
REQ-004 SHALL, with both valid, grant the requester not granted most recently (round-robin).
REQ-005 SHALL update the last-grant pointer only on a grant.
REQ-006 SHALL require requesters to hold valid, address and value stable until ready; a transfer occurs on valid & ready at the edge.
REQ-007 SHALL register the granted address/value into the output stage; REG_write_* are valid for exactly one cycle, in the cycle after the grant (latency 1).
REQ-008 SHALL accept a grant to address 0, consume it, and keep REG_write_enable at 0 for it.
REQ-009 SHALL drive REG_write_enable to 0 in any cycle that follows a cycle with no grant.
REQ-010 SHALL sustain one write per cycle under back-to-back requests, with no bubble.
REQ-011 SHALL assert WB_hazard_rsN when rsN is nonzero and matches either of:
- the address of any valid requester, or
- the address of the output stage while REG_write_enable is 1.
REQ-012 SHALL compute hazards combinationally, in the same cycle as the query.
REQ-013 SHALL hold WB_hazard_rsN at 0 when rsN is 0.

Reset
REQ-014 SHALL, while SYS_reset is 1 at an edge:
- clear REG_write_enable, REG_write_address and REG_write_value to 0;
- set the last-grant pointer to MEM, so the first tie goes to ALU.
REQ-015 SHALL hold ALU_wb_ready and MEM_wb_ready at 0 while SYS_reset is 1; no transfer occurs during reset.
REQ-016 SHALL discard an in-flight output-stage write on mid-operation reset; REG_write_enable is 0 in the following cycle.

Configuration
REQ-017 SHALL, with macro REGFILE_WB_BYPASS_EN defined, add two forwarding path pairs:
- outputs WB_fwd_rs1_valid (1), WB_fwd_rs1_data (32), WB_fwd_rs2_valid (1), WB_fwd_rs2_data (32);
- fwd_valid = 1 when rsN is nonzero, REG_write_enable is 1 and rsN equals REG_write_address;
- fwd_data = REG_write_value.
REQ-018 SHALL, with REGFILE_WB_BYPASS_EN defined, exclude the output-stage match from WB_hazard_rsN; hazard then covers valid requesters only.
REQ-019 SHALL, without REGFILE_WB_BYPASS_EN, omit the forwarding ports entirely; hazard per REQ-011.

Verification
REQ-020 Reset cycle, then ALU_wb_valid=1, addr=5, value=0xDEADBEEF for 1 cycle:
- ALU_wb_ready=1 in that cycle;
- next cycle REG_write_enable=1, address=5, value=0xDEADBEEF;
- enable=0 in the cycle after.
REQ-021 Both valid continuously (ALU addr 3 / 0x11111111, MEM addr 4 / 0x22222222), each new request presented after its grant:
- grants alternate ALU, MEM, ALU, MEM from the first cycle after reset;
- REG_write_enable stays 1 in consecutive cycles.
REQ-022 MEM_wb_valid=1, addr=0, value=0xFFFFFFFF:
- MEM_wb_ready=1;
- REG_write_enable=0 in the next cycle.
REQ-023 ALU valid, addr 7, held back by MEM winning the tie; rs1=7, rs2=0:
- WB_hazard_rs1=1 and WB_hazard_rs2=0 while pending;
- with REGFILE_WB_BYPASS_EN, during the write cycle WB_fwd_rs1_valid=1, data matches, and WB_hazard_rs1=0.
REQ-024 Grant ALU addr 9 / 0x12345678, then SYS_reset=1 on the next edge:
- REG_write_enable=0 after reset;
- the next tie with both valid is granted to ALU.
